// File: rtl/banked_instr_mem_ctrl.sv
// Instruction-memory controller for NUM_BANKS 32x512 SRAM macros.
// Run/drain/load modes, 1-cycle fetch, load count/checksum, range error.
module banked_instr_mem_ctrl #(
   parameter  int NUM_BANKS = 8,
   parameter  int ROW_W     = 9,
   localparam int BSEL_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
   localparam int ADDR_W    = BSEL_W + ROW_W + 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load_mode,
   input  logic                    fetch_valid,
   output logic                    fetch_ready,
   input  logic [ADDR_W-1:0]       fetch_addr,
   output logic                    instr_valid,
   output logic [15:0]             instr,
   input  logic                    load_valid,
   output logic                    load_ready,
   input  logic [ADDR_W-1:0]       load_addr,
   input  logic [15:0]             load_data,
   output logic [NUM_BANKS-1:0]    mem_csb,
   output logic                    mem_web,
   output logic [3:0]              mem_wmask,
   output logic [ROW_W-1:0]        mem_addr,
   output logic [31:0]             mem_din,
   input  logic [NUM_BANKS*32-1:0] mem_dout,
   output logic [15:0]             load_count,
   output logic [15:0]             load_sum,
   output logic                    range_err
);

   localparam logic [1:0] RUN   = 2'd0;
   localparam logic [1:0] DRAIN = 2'd1;
   localparam logic [1:0] LOAD  = 2'd2;

   localparam logic [BSEL_W:0] NB = (BSEL_W+1)'(NUM_BANKS);

   logic [1:0]        r_state;
   logic              r_rd_valid;
   logic              r_rd_inr;
   logic              r_rd_half;
   logic [BSEL_W-1:0] r_rd_bank;
   logic [15:0]       r_count;
   logic [15:0]       r_sum;
   logic              r_err;

   logic              w_fetch_acc;
   logic              w_load_acc;
   logic [BSEL_W-1:0] w_f_bank;
   logic [ROW_W-1:0]  w_f_row;
   logic              w_f_half;
   logic              w_f_inr;
   logic [BSEL_W-1:0] w_l_bank;
   logic [ROW_W-1:0]  w_l_row;
   logic              w_l_half;
   logic              w_l_inr;
   logic [BSEL_W-1:0] w_bank;
   logic              w_hit;
   logic [31:0]       w_word;

   assign fetch_ready = (r_state == RUN);
   assign load_ready  = (r_state == LOAD);
   assign w_fetch_acc = fetch_valid && fetch_ready;
   assign w_load_acc  = load_valid && load_ready;

   assign w_f_half = fetch_addr[0];
   assign w_f_row  = fetch_addr[ROW_W:1];
   assign w_f_bank = fetch_addr[ADDR_W-1:ROW_W+1];
   assign w_f_inr  = ({1'b0, w_f_bank} < NB);

   assign w_l_half = load_addr[0];
   assign w_l_row  = load_addr[ROW_W:1];
   assign w_l_bank = load_addr[ADDR_W-1:ROW_W+1];
   assign w_l_inr  = ({1'b0, w_l_bank} < NB);

   // Fetch and load accepts are exclusive by state, so one bank select suffices
   assign w_bank = (r_state == LOAD) ? w_l_bank : w_f_bank;
   assign w_hit  = (w_fetch_acc && w_f_inr) || (w_load_acc && w_l_inr);

   assign instr_valid = r_rd_valid;
   assign load_count  = r_count;
   assign load_sum    = r_sum;
   assign range_err   = r_err;

   // Drive the shared SRAM bus; idle values when nothing is accepted
   always_comb begin
      mem_csb   = '1;
      mem_web   = 1'b1;
      mem_wmask = 4'b0000;
      mem_addr  = '0;
      mem_din   = 32'h0;
      if (w_hit) begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            if (w_bank == BSEL_W'(b)) mem_csb[b] = 1'b0;
         end
      end
      if (w_fetch_acc && w_f_inr) begin
         mem_addr = w_f_row;
      end else if (w_load_acc && w_l_inr) begin
         mem_web   = 1'b0;
         mem_addr  = w_l_row;
         mem_din   = {load_data, load_data};
         mem_wmask = w_l_half ? 4'b1100 : 4'b0011;
      end
   end

   // Select the returning bank word and halfword; zero when not valid
   always_comb begin
      w_word = 32'h0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (r_rd_bank == BSEL_W'(b)) w_word = mem_dout[32*b +: 32];
      end
      instr = 16'h0;
      if (r_rd_valid && r_rd_inr) instr = r_rd_half ? w_word[31:16] : w_word[15:0];
   end

   // Mode FSM: RUN -> DRAIN (one cycle) -> LOAD -> RUN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= RUN;
      end else begin
         case (r_state)
            RUN:     if (load_mode) r_state <= DRAIN;
            DRAIN:   r_state <= LOAD;
            LOAD:    if (!load_mode) r_state <= RUN;
            default: r_state <= RUN;
         endcase
      end
   end

   // Remember the accepted fetch so data can be steered one cycle later
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rd_valid <= 1'b0;
         r_rd_inr   <= 1'b0;
         r_rd_half  <= 1'b0;
         r_rd_bank  <= '0;
      end else begin
         r_rd_valid <= w_fetch_acc;
         if (w_fetch_acc) begin
            r_rd_inr  <= w_f_inr;
            r_rd_half <= w_f_half;
            r_rd_bank <= w_f_bank;
         end
      end
   end

   // Count and checksum of in-range loads, restarted on every drain
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= 16'h0;
         r_sum   <= 16'h0;
      end else if (r_state == DRAIN) begin
         r_count <= 16'h0;
         r_sum   <= 16'h0;
      end else if (w_load_acc && w_l_inr) begin
         r_count <= r_count + 16'h1;
         r_sum   <= r_sum + load_data;
      end
   end

   // Sticky flag for any accepted access to a missing bank
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_err <= 1'b0;
      end else if ((w_fetch_acc && !w_f_inr) || (w_load_acc && !w_l_inr)) begin
         r_err <= 1'b1;
      end
   end

endmodule

// File: doc/banked_instr_mem_ctrl.md
# banked_instr_mem_ctrl

Parametrised instruction-memory controller sitting between the processor fetch port, a program loader and NUM_BANKS single-port 32x512 SRAM macros. It maps a halfword instruction address onto bank/row/half, drives per-bank chip selects, and returns 16-bit instructions with one-cycle latency. A load mode, entered via a drain state, lets the loader write 16-bit words through a valid/ready handshake. The controller keeps a word count and checksum of loaded data and raises a sticky error flag on out-of-range accesses.

## Interface
Parameters:
- NUM_BANKS, 8: number of SRAM banks, 1..16, need not be a power of two.
- ROW_W, 9: SRAM row address width.
- BSEL_W, derived: max(1, clog2(NUM_BANKS)); ADDR_W = BSEL_W+ROW_W+1 (13 at defaults).

Ports:
- clk  in  1  sole clock; SRAM macros share it.
- reset  in  1  asynchronous, active-low reset.
- load_mode  in  1  1 requests load mode, 0 requests run mode.
- fetch_valid  in  1  fetch request.
- fetch_ready  out  1  request accepted this cycle.
- fetch_addr  in  ADDR_W  halfword instruction address.
- instr_valid  out  1  instr holds returned data.
- instr  out  16  fetched instruction.
- load_valid  in  1  loader write request.
- load_ready  out  1  write accepted this cycle.
- load_addr  in  ADDR_W  halfword write address.
- load_data  in  16  word to write.
- mem_csb  out  NUM_BANKS  active-low per-bank chip select.
- mem_web  out  1  active-low write enable, shared.
- mem_wmask  out  4  byte write mask, shared.
- mem_addr  out  ROW_W  row address, shared.
- mem_din  out  32  write data, shared.
- mem_dout  in  NUM_BANKS*32  bank b read data at [32b+31:32b].
- load_count  out  16  accepted in-range loads since load-mode entry.
- load_sum  out  16  mod-2^16 sum of in-range load_data since load-mode entry.
- range_err  out  1  sticky out-of-range flag.

## Operation
- Address split: half = addr[0] (1 = upper halfword [31:16]); row = addr[ROW_W:1]; bank = addr[ADDR_W-1:ROW_W+1]. Bank >= NUM_BANKS is out of range.
- States: RUN, DRAIN, LOAD. Reset enters RUN.
- RUN: fetch_ready=1, load_ready=0. load_mode=1 moves to DRAIN at next edge.
- DRAIN: one cycle; both readies 0; load_count and load_sum cleared; always moves to LOAD.
- LOAD: load_ready=1, fetch_ready=0. load_mode=0 moves to RUN at next edge.
- Fetch accept (fetch_valid & fetch_ready): in-range: mem_csb[bank]=0, mem_web=1, mem_addr=row, combinationally in the accept cycle. Bank, half and in-range bit are registered.
- Out-of-range fetch: no csb asserted; next-cycle instr=16'h0000; range_err set.
- Load accept (load_valid & load_ready): in-range: mem_csb[bank]=0, mem_web=0, mem_din={load_data,load_data}, mem_wmask = half ? 4'b1100 : 4'b0011. load_count+1 and load_sum+load_data, both wrapping.
- Out-of-range load: accepted, no write, counters unchanged, range_err set.
- Idle: all mem_csb=1, mem_web=1, mem_wmask=0, mem_addr=0, mem_din=0.
- range_err is cleared only by reset.

## Timing
- Reset values: state RUN; fetch_ready=1; load_ready=0; instr_valid=0; instr=0; load_count=0; load_sum=0; range_err=0; mem_csb all 1; mem_web=1.
- Fetch latency is 1. Accept at edge N gives instr_valid=1 in cycle N+1, with instr muxed combinationally from mem_dout of the registered bank/half. Back-to-back fetches sustain 1 per cycle.
- instr_valid is 0 in any cycle that does not follow an accepted fetch. instr is 0 when instr_valid=0.
- load_mode rising in a RUN cycle with a fetch accepted: the fetch still completes, returning in the DRAIN cycle. This is the purpose of DRAIN.
- load_mode falling in a LOAD cycle with load_valid=1: the write is accepted; RUN starts at the next edge. The first fetch can be accepted that cycle and may read the just-written row.
- Reset asserted mid-operation: all state clears immediately; a pending instr_valid is dropped.
- load_count, load_sum and range_err update at the accept edge.

## Test plan
- Reset, then fetch addr 13'h0000..0003 back-to-back with mem_dout bank0=32'hBEEF_1234 -> instr 1234, BEEF, 1234, BEEF on cycles 1..4, instr_valid held 1, mem_csb=8'hFE.
- load_mode=1; observe 1 DRAIN cycle; write 0x1111 to addr 0x0401 and 0x2222 to 0x0400 -> bank1 csb low, wmask 1100 then 0011, row 0x000; load_count=2, load_sum=0x3333.
- Fetch accepted in the same cycle load_mode rises -> instr_valid=1 during DRAIN; load_ready=0 during DRAIN.
- NUM_BANKS=6, fetch addr with bank=7 -> no csb low, instr=0, instr_valid=1, range_err=1 and stays 1.
- 65537 loads of 0x0001 -> load_count and load_sum wrap to 0x0001; re-entering load mode clears both to 0.
- Assert reset during back-to-back fetches -> instr_valid=0 and state RUN asynchronously; fetch resumes the cycle after deassertion.
